qpsk_symbol_sched: RTL and testbench
====================================

// Module: qpsk_symbol_sched
// PURPOSE
//  Sequences the carrier sine LUT for the QPSK modulator. Accepts 2-bit symbols
//  over a valid/ready handshake and, for each symbol, drives the LUT read address
//  through CARRIER_PERIODS full carrier cycles, offset by the Gray-coded symbol
//  phase. It sits between the bit-to-dibit framer and the sine ROM/DAC path, and
//  provides back-to-back symbols with no gap and an underrun flag.
// PARAMETERS
//  TABLE_LEN        32  LUT entries per carrier period; multiple of 4, power of 2
//  ADDR_W           5   LUT address width; 2**ADDR_W == TABLE_LEN
//  CARRIER_PERIODS  2   carrier periods per symbol (>=1)
//  CNT_W            16  width of symbol counter
// PORTS
//  Clk        in   1       system clock, all logic on posedge
//  Rst        in   1       synchronous reset, active-high
//  sym_valid  in   1       upstream has a symbol on sym_data
//  sym_data   in   2       dibit {I,Q}
//  sym_ready  out  1       block accepts sym_data this cycle
//  lut_addr   out  ADDR_W  sine LUT read address
//  lut_en     out  1       lut_addr valid / DAC sample strobe
//  sym_start  out  1       1-cycle pulse on first sample of each symbol
//  underrun   out  1       1-cycle pulse when a symbol ends with none pending
//  sym_count  out  CNT_W   symbols accepted since reset, wraps
// BEHAVIOUR
//  - Reset: state=IDLE; lut_addr=0, lut_en=0, sym_start=0, underrun=0,
//    sym_count=0; counters cleared. Rst mid-symbol aborts it next edge; the
//    latched symbol is discarded. No underrun pulse is produced by reset.
//  - Phase map (Q=TABLE_LEN/4): 00->0, 01->Q, 11->2Q, 10->3Q.
//  - Counters: samp (0..TABLE_LEN-1), per (0..CARRIER_PERIODS-1).
//    last = RUN && samp==TABLE_LEN-1 && per==CARRIER_PERIODS-1.
//  - sym_ready = (state==IDLE) || last; combinational, no dependency on sym_valid.
//  - Accept = sym_valid && sym_ready at posedge; latch phase; sym_count += 1.
//  - FSM IDLE: on accept -> RUN; samp=0, per=0. Otherwise remain in IDLE with
//    lut_en=0 and lut_addr=0.
//  - FSM RUN: each cycle lut_en=1, lut_addr=(samp+phase) mod TABLE_LEN (natural
//    ADDR_W wrap). samp increments, wraps to 0 and then per increments.
//    At last: with accept -> stay in RUN, samp=per=0, new phase (no idle cycle).
//             without accept -> IDLE next cycle; underrun=1 for that cycle.
//  - Latency: accept at edge N -> registered outputs after edge N show the first
//    sample (lut_addr=phase, lut_en=1, sym_start=1). Each symbol occupies exactly
//    TABLE_LEN*CARRIER_PERIODS consecutive lut_en cycles.
//  - sym_start is high only on samp==0 && per==0 of a symbol.
//  - sym_data is sampled only on accept. Changes while sym_ready=0 are ignored.
//  - sym_count wraps from 2**CNT_W-1 to 0 without a flag.
// TESTING (TABLE_LEN=32, CARRIER_PERIODS=2)
//  1 Reset: hold Rst 3 cycles with sym_valid=1 -> all outputs 0, sym_ready=1
//    after release, sym_count=0.
//  2 Single sym 01: valid 1 cycle in IDLE -> next cycle lut_addr=8, sym_start=1;
//    addr 8..31,0..7 twice over 64 lut_en cycles; then underrun=1, lut_en=0.
//  3 Back-to-back 00,11,10 held valid -> 192 contiguous lut_en cycles; sym_start
//    at cycles 0/64/128; first addrs 0,16,24; no underrun until after 3rd symbol.
//  4 Ready gating: sym_valid high mid-symbol -> sym_ready=0 until the last sample
//    (samp=31, per=1); data changes before then are ignored.
//  5 Rst at sample 20 of a symbol with next valid pending -> IDLE next edge,
//    lut_en=0, no underrun, pending symbol not counted.
//  6 CNT_W=4: 17 symbols -> sym_count wraps 15->0->1.

Source files
------------

// File: rtl/qpsk_symbol_sched.sv
// QPSK carrier sequencer: walks the sine LUT through CARRIER_PERIODS cycles per
// accepted dibit, offset by its Gray-coded phase, with gapless back-to-back symbols.
module qpsk_symbol_sched #(
  parameter int unsigned TABLE_LEN       = 32,
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned CARRIER_PERIODS = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  output logic              sym_ready,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              lut_en,
  output logic              sym_start,
  output logic              underrun,
  output logic [CNT_W-1:0]  sym_count
);

  localparam int unsigned PER_W = (CARRIER_PERIODS > 1) ? $clog2(CARRIER_PERIODS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  samp_q, samp_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [ADDR_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               under_q, under_d;

  logic               samp_wrap;
  logic               last;
  logic               accept;
  logic [1:0]         quadrant;

  always_comb begin
    samp_wrap = (samp_q == ADDR_W'(TABLE_LEN - 1));
    last      = (state_q == RUN) && samp_wrap && (per_q == PER_W'(CARRIER_PERIODS - 1));
    sym_ready = (state_q == IDLE) || last;
    accept    = sym_valid && sym_ready;
    // Gray decode: 00->0, 01->1, 11->2, 10->3 quarter periods
    quadrant  = {sym_data[1], sym_data[1] ^ sym_data[0]};

    state_d = state_q;
    samp_d  = samp_q;
    per_d   = per_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    under_d = 1'b0;

    if (accept) begin
      state_d = RUN;
      samp_d  = '0;
      per_d   = '0;
      phase_d = ADDR_W'(quadrant) << (ADDR_W - 2);
      cnt_d   = cnt_q + 1'b1;
    end else if (state_q == RUN) begin
      if (last) begin
        state_d = IDLE;
        samp_d  = '0;
        per_d   = '0;
        under_d = 1'b1;
      end else begin
        samp_d = samp_q + 1'b1;
        if (samp_wrap) begin
          per_d = per_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      per_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      per_q   <= per_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      under_q <= under_d;
    end
  end

  // Outputs are decoded straight from registered state, so the sample shown is the one the counters describe.
  always_comb begin
    lut_en    = (state_q == RUN);
    lut_addr  = lut_en ? (samp_q + phase_q) : '0;
    sym_start = lut_en && (samp_q == '0) && (per_q == '0);
    underrun  = under_q;
    sym_count = cnt_q;
  end

endmodule

// File: tb/tb_qpsk_symbol_sched.sv
// Randomized bench for qpsk_symbol_sched against a sample-queue reference model.
module tb_qpsk_symbol_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready, lut_en, sym_start, underrun;
  logic [4:0]  lut_addr;
  logic [15:0] sym_count;

  logic        sym_ready4, lut_en4, sym_start4, underrun4;
  logic [4:0]  lut_addr4;
  logic [3:0]  sym_count4;

  always #5 Clk = ~Clk;

  qpsk_symbol_sched #(.TABLE_LEN(32), .ADDR_W(5), .CARRIER_PERIODS(2), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .lut_addr(lut_addr), .lut_en(lut_en),
    .sym_start(sym_start), .underrun(underrun), .sym_count(sym_count)
  );

  qpsk_symbol_sched #(.TABLE_LEN(32), .ADDR_W(5), .CARRIER_PERIODS(2), .CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready4), .lut_addr(lut_addr4), .lut_en(lut_en4),
    .sym_start(sym_start4), .underrun(underrun4), .sym_count(sym_count4)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic       start;
  } samp_t;

  samp_t       pend[$];
  samp_t       cur;
  bit          cur_v   = 1'b0;
  bit          m_under = 1'b0;
  int unsigned m_cnt   = 0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model is ready when idle or when the sample on show is the last of its symbol.
  function automatic bit m_ready();
    return !cur_v || (pend.size() == 0);
  endfunction

  task automatic step(input bit v, input logic [1:0] d, input bit r);
    bit          acc;
    int unsigned ph;
    samp_t       s;
    sym_valid = v;
    sym_data  = d;
    Rst       = r;
    if (r) begin
      pend.delete();
      cur_v   = 1'b0;
      m_under = 1'b0;
      m_cnt   = 0;
    end else begin
      acc     = v && m_ready();
      m_under = cur_v && (pend.size() == 0) && !acc;
      if (acc) begin
        m_cnt++;
        case (d)
          2'b00:   ph = 0;
          2'b01:   ph = 8;
          2'b11:   ph = 16;
          default: ph = 24;
        endcase
        for (int unsigned p = 0; p < 2; p++)
          for (int unsigned i = 0; i < 32; i++) begin
            s.addr  = 5'((i + ph) % 32);
            s.start = (p == 0) && (i == 0);
            pend.push_back(s);
          end
      end
      if (pend.size() > 0) begin
        cur   = pend.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    check_eq("lut_en",     32'(lut_en),     32'(cur_v));
    check_eq("lut_addr",   32'(lut_addr),   cur_v ? 32'(cur.addr) : 32'd0);
    check_eq("sym_start",  32'(sym_start),  32'(cur_v && cur.start));
    check_eq("underrun",   32'(underrun),   32'(m_under));
    check_eq("sym_ready",  32'(sym_ready),  32'(m_ready()));
    check_eq("sym_count",  32'(sym_count),  m_cnt % 65536);
    check_eq("sym_count4", 32'(sym_count4), m_cnt % 16);
    check_eq("lut_addr4",  32'(lut_addr4),  cur_v ? 32'(cur.addr) : 32'd0);
  endtask

  logic [1:0] seq [3];
  int unsigned idx;
  int unsigned pv;
  bit          rdy;

  initial begin
    // Reset held three cycles with valid asserted
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    step(1'b0, 2'b00, 1'b0);

    // Single symbol 01 then starve
    step(1'b1, 2'b01, 1'b0);
    for (int unsigned i = 0; i < 70; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);

    // Back-to-back 00, 11, 10 with valid held
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b10;
    idx = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      rdy = m_ready();
      if (idx < 3) step(1'b1, seq[idx], 1'b0);
      else         step(1'b0, 2'b00, 1'b0);
      if (rdy && idx < 3) idx++;
    end

    // Reset mid-symbol with next symbol pending and changing data
    step(1'b1, 2'b11, 1'b0);
    for (int unsigned i = 0; i < 19; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    step(1'b1, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b0);

    // Randomized traffic: dense phase then sparse phase with idle gaps
    for (int unsigned i = 0; i < 3000; i++) begin
      pv = (i < 1500) ? 95 : 2;
      step($urandom_range(0, 99) < pv, 2'($urandom_range(0, 3)), $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
